iter_multiplier: RTL and testbench
==================================

# iter_multiplier

Parametrised multi-cycle multiplier for the execute stage of the ARM pipeline. It covers MUL, MLA, UMULL, SMULL, UMLAL and SMLAL. It replaces the single-cycle combinational Rm×Rs multiplier with a shift-add datapath that retires STEP multiplier bits per cycle. It exchanges operands and results with the pipeline through valid/ready handshakes and also produces the N/Z flags needed by S-suffixed instructions.

## Interface
- WIDTH, 32, operand width; must be a multiple of STEP.
- STEP, 2, multiplier bits retired per RUN cycle; legal values are 1, 2 and 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept a new operation.
- op  in  3  mult_op_e value.
- rm  in  WIDTH  multiplicand (Rm).
- rs  in  WIDTH  multiplier (Rs).
- acc_lo  in  WIDTH  accumulate input; Rn for MLA, RdLo for long accumulate.
- acc_hi  in  WIDTH  RdHi for long accumulate; ignored for 32-bit ops.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- res_lo  out  WIDTH  low result word.
- res_hi  out  WIDTH  high result word; 0 for MUL/MLA.
- flag_n  out  1  N flag.
- flag_z  out  1  Z flag.

## Operation
- FSM states: IDLE, RUN, FIXUP, DONE.
- IDLE: in_ready=1. The transfer `in_valid && in_ready` latches op, rm, rs, acc_lo and acc_hi, clears the 2·WIDTH product register and sets the step counter to WIDTH/STEP. Next state is RUN.
- Signed ops (SMULL, SMLAL): latch |rm| and |rs| and record the sign `neg = rm[MSB] ^ rs[MSB]`. The most-negative value gives |x| = 2^(WIDTH-1), which is representable unsigned.
- RUN, each cycle:
  - add `multiplicand × (low STEP bits of multiplier)`, shifted into position, to the product;
  - shift the multiplier right by STEP;
  - decrement the counter.
  - When the counter reaches 1, go to FIXUP.
- FIXUP (one cycle):
  - if neg, negate the 2·WIDTH product (two's complement);
  - add the accumulate value: {acc_hi, acc_lo} for long ops, zero-extended acc_lo for MLA;
  - drive the outputs, then go to DONE.
- Arithmetic:
  - all sums wrap modulo 2^(2·WIDTH);
  - for MUL/MLA, res_lo = product[WIDTH-1:0] and res_hi = 0.
- Flags:
  - 32-bit ops: flag_n = res_lo[MSB], flag_z = (res_lo == 0).
  - Long ops: flag_n = res_hi[MSB], flag_z = ({res_hi, res_lo} == 0).
- DONE: out_valid=1. Results and flags are held stable until `out_valid && out_ready`, then next state is IDLE.
- in_ready=0 in RUN, FIXUP and DONE. in_valid asserted in those states is ignored, with no side effects.
- Illegal op codes 6 and 7 are treated as MUL.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, res_lo=0, res_hi=0, flag_n=0, flag_z=0.
- Latency: acceptance in cycle T gives out_valid in cycle T+WIDTH/STEP+2. For the defaults that is T+18.
- Throughput: one op per WIDTH/STEP+3 cycles when out_ready is held high. There is no acceptance in the same cycle as the DONE handshake.
- rst asserted in any state: next cycle shows the reset values, and the in-flight op is discarded with no output.
- rst has priority over every handshake in the same cycle.

## Configuration
- MULT_ACC_EN defined: MLA, UMLAL and SMLAL add the accumulate inputs in FIXUP.
- MULT_ACC_EN undefined:
  - the accumulate adder is not built;
  - acc_lo and acc_hi are ignored;
  - MLA behaves as MUL, UMLAL as UMULL, SMLAL as SMULL;
  - latency is unchanged.

## Structure
- mult_pkg holds:
  - mult_op_e: MUL=0, MLA=1, UMULL=2, SMULL=3, UMLAL=4, SMLAL=5;
  - mult_state_e;
  - helper functions is_long(op), is_signed(op) and is_acc(op).
- Sub-module mult_step (combinational): inputs are the multiplicand, STEP multiplier bits and the partial product; output is the next partial product. It is instantiated once, in the RUN datapath.

## Test plan
All scenarios use WIDTH=32, STEP=2, MULT_ACC_EN defined.
- MUL rm=7, rs=6 accepted in cycle T -> out_valid first in cycle T+18; res_lo=42, res_hi=0, flag_n=0, flag_z=0.
- SMULL rm=0xFFFFFFFF, rs=2 -> {res_hi,res_lo}=0xFFFFFFFF_FFFFFFFE, flag_n=1. SMULL rm=0x80000000, rs=0x80000000 -> 0x40000000_00000000.
- UMULL rm=rs=0xFFFFFFFF -> res_hi=0xFFFFFFFE, res_lo=0x00000001. UMLAL on the same operands with acc={0,0xFFFFFFFF} -> res_hi=0xFFFFFFFF, res_lo=0.
- MLA rm=3, rs=4, acc_lo=0xFFFFFFF4 -> res_lo=0, flag_z=1. Rebuilt without MULT_ACC_EN, the same stimulus gives res_lo=12, flag_z=0.
- Backpressure: out_ready held low for 5 cycles in DONE -> outputs stable, in_ready=0. A new in_valid in that window is not accepted; it is accepted in IDLE after the handshake.
- rst pulsed in the 5th RUN cycle -> next cycle in_ready=1, out_valid=0, res=0, and no result ever appears for that op.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and op-decode helpers for the iterative ARM multiplier.
package mult_pkg;

    typedef enum logic [2:0] {
        MUL   = 3'd0,
        MLA   = 3'd1,
        UMULL = 3'd2,
        SMULL = 3'd3,
        UMLAL = 3'd4,
        SMLAL = 3'd5
    } mult_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mult_state_e;

    function automatic logic is_long(input mult_op_e op);
        return op inside {UMULL, SMULL, UMLAL, SMLAL};
    endfunction

    function automatic logic is_signed(input mult_op_e op);
        return op inside {SMULL, SMLAL};
    endfunction

    function automatic logic is_acc(input mult_op_e op);
        return op inside {MLA, UMLAL, SMLAL};
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: folds STEP multiplier bits into the partial product.
module mult_step #(
    parameter int W2   = 64,
    parameter int STEP = 2
) (
    input  logic [W2-1:0]   mcand,
    input  logic [STEP-1:0] bits,
    input  logic [W2-1:0]   partial,
    output logic [W2-1:0]   sum
);

    // NOTE: blocking assignments here build an adder chain inside one
    // combinational evaluation; the default first keeps it latch-free.
    always_comb begin
        sum = partial;
        for (int i = 0; i < STEP; i++) begin
            if (bits[i]) sum = sum + (mcand << i);
        end
    end

endmodule

// File: rtl/iter_multiplier.sv
// Multi-cycle shift-add multiplier (MUL/MLA/UMULL/SMULL/UMLAL/SMLAL) with N/Z flags.
// Define MULT_ACC_EN to build the accumulate adder; otherwise accumulate ops degrade to plain multiplies.
module iter_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = $clog2(NSTEPS + 1);
    localparam int W2     = 2 * WIDTH;

    mult_state_e      state;
    mult_op_e         op_q;
    mult_op_e         op_in;
    logic [W2-1:0]    mcand;
    logic [W2-1:0]    product;
    logic [W2-1:0]    product_next;
    logic [W2-1:0]    fixed;
    logic [W2-1:0]    acc_val;
    logic [W2-1:0]    result;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] rm_abs;
    logic [WIDTH-1:0] rs_abs;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             accept;
    logic             flag_n_d;
    logic             flag_z_d;

`ifdef MULT_ACC_EN
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] acc_hi_q;
`else
    logic acc_unused;
    assign acc_unused = ^{acc_lo, acc_hi};
`endif

    assign accept = in_valid && in_ready;

    // Codes 6 and 7 fall back to MUL; signed ops run on magnitudes, and the
    // most-negative input negates to itself, which reads correctly as unsigned.
    always_comb begin
        op_in  = (op > 3'd5) ? MUL : mult_op_e'(op);
        rm_abs = (is_signed(op_in) && rm[WIDTH-1]) ? -rm : rm;
        rs_abs = (is_signed(op_in) && rs[WIDTH-1]) ? -rs : rs;
    end

    mult_step #(.W2(W2), .STEP(STEP)) u_step (
        .mcand   (mcand),
        .bits    (mplier[STEP-1:0]),
        .partial (product),
        .sum     (product_next)
    );

    always_comb begin
        fixed   = neg ? -product : product;
        acc_val = '0;
`ifdef MULT_ACC_EN
        if (is_acc(op_q)) begin
            acc_val = is_long(op_q) ? {acc_hi_q, acc_lo_q} : {{WIDTH{1'b0}}, acc_lo_q};
        end
`endif
        result = fixed + acc_val;
        if (!is_long(op_q)) result[W2-1:WIDTH] = '0;
        flag_n_d = is_long(op_q) ? result[W2-1] : result[WIDTH-1];
        flag_z_d = is_long(op_q) ? (result == '0) : (result[WIDTH-1:0] == '0);
    end

    // NOTE: datapath registers carry no reset; each one is loaded on
    // acceptance before anything reads it, so reset only touches control.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    op_q    <= op_in;
                    mcand   <= {{WIDTH{1'b0}}, rm_abs};
                    mplier  <= rs_abs;
                    neg     <= is_signed(op_in) && (rm[WIDTH-1] ^ rs[WIDTH-1]);
                    product <= '0;
                    cnt     <= CW'(NSTEPS);
`ifdef MULT_ACC_EN
                    acc_lo_q <= acc_lo;
                    acc_hi_q <= acc_hi;
`endif
                end
            end
            RUN: begin
                product <= product_next;
                mcand   <= mcand << STEP;
                mplier  <= mplier >> STEP;
                cnt     <= cnt - CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res_lo    <= '0;
            res_hi    <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    res_lo    <= result[WIDTH-1:0];
                    res_hi    <= result[W2-1:WIDTH];
                    flag_n    <= flag_n_d;
                    flag_z    <= flag_z_d;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier (WIDTH=32, STEP=2) against an arithmetic reference model.
module tb_iter_multiplier;

    localparam int WIDTH  = 32;
    localparam int STEP   = 2;
    localparam int LAT    = WIDTH / STEP + 1;  // edges from accept edge to out_valid visible
    localparam int PERIOD = WIDTH / STEP + 3;
`ifdef MULT_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [2:0]       op        = 3'd0;
    logic [WIDTH-1:0] rm        = '0;
    logic [WIDTH-1:0] rs        = '0;
    logic [WIDTH-1:0] acc_lo    = '0;
    logic [WIDTH-1:0] acc_hi    = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             flag_n;
    logic             flag_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_multiplier #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rm        (rm),
        .rs        (rs),
        .acc_lo    (acc_lo),
        .acc_hi    (acc_hi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_lo    (res_lo),
        .res_hi    (res_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference: the ARM result as plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o_in, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] lo,
                                          input logic [31:0] hi);
        logic [2:0]  o;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        o = (o_in > 3'd5) ? 3'd0 : o_in;
        if (o == 3'd3 || o == 3'd5) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        if (ACC_EN && o == 3'd1) p = p + {32'd0, lo};
        if (ACC_EN && (o == 3'd4 || o == 3'd5)) p = p + {hi, lo};
        if (o < 3'd2) p[63:32] = '0;
        return p;
    endfunction

    function automatic logic model_n(input logic [2:0] o_in, input logic [63:0] p);
        return (o_in inside {3'd2, 3'd3, 3'd4, 3'd5}) ? p[63] : p[31];
    endfunction

    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] lo, input logic [31:0] hi);
        op = o; rm = a; rs = b; acc_lo = lo; acc_hi = hi; in_valid = 1'b1;
        check1("in_ready_idle", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check1("in_ready_busy", in_ready, 1'b0);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check1("out_valid_seen", out_valid, 1'b1);
    endtask

    task automatic expect_result(input string tag, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] lo,
                                 input logic [31:0] hi);
        logic [63:0] e;
        e = model(o, a, b, lo, hi);
        check({tag, "_res"}, {res_hi, res_lo}, e);
        check1({tag, "_n"}, flag_n, model_n(o, e));
        check1({tag, "_z"}, flag_z, e == 64'd0);
        check1({tag, "_in_ready_done"}, in_ready, 1'b0);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check1("hs_out_valid_low", out_valid, 1'b0);
        check1("hs_in_ready_high", in_ready, 1'b1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lo, input logic [31:0] hi);
        int lat;
        start_op(o, a, b, lo, hi);
        wait_result(lat);
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        expect_result(tag, o, a, b, lo, hi);
        handshake();
    endtask

    initial begin
        int          lat;
        int          acc_q[$];
        logic        pre;
        logic        seen;
        logic [63:0] held;
        logic [2:0]  ro;
        logic [31:0] ra, rb, rl, rh;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_res", {res_hi, res_lo}, 64'd0);
        check1("rst_flag_n", flag_n, 1'b0);
        check1("rst_flag_z", flag_z, 1'b0);

        // Directed cases from the arithmetic corners.
        do_op("mul_7x6", 3'd0, 32'd7, 32'd6, 32'd0, 32'd0);
        check("mul_42_const", {res_hi, res_lo}, 64'd42);
        do_op("smull_m1x2", 3'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
        do_op("smull_min", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
        check("smull_min_const", {res_hi, res_lo}, 64'h4000_0000_0000_0000);
        do_op("umull_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        check("umull_max_const", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("umlal_max", 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        do_op("smlal", 3'd5, 32'hFFFF_FFF0, 32'd3, 32'h0000_0010, 32'hFFFF_FFFF);
        do_op("mla_zero", 3'd1, 32'd3, 32'd4, 32'hFFFF_FFF4, 32'd0);
        do_op("mul_zero", 3'd0, 32'd0, 32'h1234_5678, 32'd0, 32'd0);
        do_op("op7_as_mul", 3'd7, 32'h0001_0003, 32'h0000_0105, 32'hDEAD_BEEF, 32'd1);

        // Backpressure: result held for 5 cycles, new request ignored until IDLE.
        start_op(3'd2, 32'h89AB_CDEF, 32'h1357_9BDF, 32'd0, 32'd0);
        wait_result(lat);
        held = {res_hi, res_lo};
        op = 3'd0; rm = 32'd11; rs = 32'd13; acc_lo = 32'd0; acc_hi = 32'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_stable", {res_hi, res_lo}, held);
            check1("bp_out_valid", out_valid, 1'b1);
            check1("bp_in_ready", in_ready, 1'b0);
        end
        expect_result("bp_first", 3'd2, 32'h89AB_CDEF, 32'h1357_9BDF, 32'd0, 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check1("bp_idle_in_ready", in_ready, 1'b1);
        check1("bp_idle_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check1("bp_second_accepted", in_ready, 1'b0);
        wait_result(lat);
        check("bp_second_latency", 64'(lat), 64'(LAT));
        expect_result("bp_second", 3'd0, 32'd11, 32'd13, 32'd0, 32'd0);
        handshake();

        // Throughput with in_valid and out_ready held high.
        op = 3'd0; rm = 32'd5; rs = 32'd9; in_valid = 1'b1; out_ready = 1'b1;
        for (int e = 0; e < 3 * PERIOD; e++) begin
            pre = in_ready;
            @(posedge clk); #1;
            if (pre) acc_q.push_back(e);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("tput_accepts_ge2", 64'(acc_q.size() >= 2), 64'd1);
        if (acc_q.size() >= 2) check("tput_period", 64'(acc_q[1] - acc_q[0]), 64'(PERIOD));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset during the 5th RUN cycle discards the operation.
        start_op(3'd3, 32'hFFFF_0001, 32'h7FFF_FFFF, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check1("mid_rst_in_ready", in_ready, 1'b1);
        check1("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_res", {res_hi, res_lo}, 64'd0);
        check1("mid_rst_flag_n", flag_n, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check1("mid_rst_no_output", seen, 1'b0);

        // Randomized operations, with occasional extreme operands.
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            rl = $urandom;
            rh = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'd0;
            do_op("rand", ro, ra, rb, rl, rh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
